pixel_config_driver: RTL and testbench
======================================

Name: pixel_config_driver

Overview:
- Transmit-side sequencer for the pixel configuration chain. It generates config_clk, config_data, config_en and push_en for the double-column config shift logic.
- Accepts 6-bit config words from an upstream SPI register file over a valid/ready handshake. Shifts SHIFTS_PER_ROW words per row on falling config_clk edges, then pulses push_en to load the row into pixels. Repeats for ROWS rows, then signals done.

Parameters:
- WORD_W, 6, config word width per shift
- SHIFTS_PER_ROW, 32, shifts per row (192 bits / 6)
- ROWS, 128, rows per full configuration
- HALF_PER, 2, config_clk half-period in clk_40MHz cycles (>=1)
- PUSH_CYC, 4, push_en high duration in clk_40MHz cycles (>=1)

Ports:
- clk_40MHz  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a full configuration; ignored while busy
- abort  in  1  synchronous cancel; returns to IDLE
- din  in  WORD_W  next config word
- din_valid  in  1  din is valid
- din_ready  out  1  driver accepts din this cycle
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse after last row pushed
- row_idx  out  $clog2(ROWS)  row currently being shifted/pushed
- config_clk  out  1  serial shift clock; idles high; target captures on falling edge
- config_data  out  WORD_W  word presented to the chain
- config_en  out  1  shift enable, high during row shifting
- push_en  out  1  parallel push into pixel row

Behaviour:
- Reset (rst_n=0 at a clock edge) sets every output and counter to its idle value:
  - config_clk=1
  - config_data=0, config_en=0, push_en=0
  - busy=0, done=0, din_ready=0
  - row_idx=0, internal shift_cnt=0
- All outputs are registered; none is combinational from inputs except din_ready, which is a decode of state==FETCH.
- States: IDLE, FETCH, CLK_HI, CLK_LO, PUSH, DONE.
- IDLE: on start, go to FETCH; busy=1, row_idx=0, shift_cnt=0.
- FETCH:
  - din_ready=1 and config_clk stays high.
  - On din_valid&&din_ready: config_data<=din, config_en<=1, go to CLK_HI.
  - No valid data means stall indefinitely; config_clk stays high and no edge is produced.
- CLK_HI: hold HALF_PER cycles (data setup), then config_clk<=0 and go to CLK_LO. The falling edge occurs HALF_PER+1 cycles after the accepting cycle.
- CLK_LO: hold HALF_PER cycles, then config_clk<=1.
  - If shift_cnt==SHIFTS_PER_ROW-1: shift_cnt<=0, config_en<=0, push_en<=1, go to PUSH.
  - Else: shift_cnt++, go to FETCH.
- PUSH: push_en stays high exactly PUSH_CYC cycles, then drops.
  - If row_idx==ROWS-1: go to DONE.
  - Else: row_idx++, go to FETCH.
- DONE: done=1 for one cycle, busy<=0, row_idx<=0, go to IDLE.
- config_en is high across the entire row, including FETCH stalls between words. It is never high together with push_en.
- config_data holds its last value until the next accept.
- abort in any state: on the next cycle force IDLE values (config_clk=1, config_en=0, push_en=0, busy=0, counters 0); no done pulse. abort wins over a simultaneous start or handshake. A falling edge already issued is not undone.
- start while busy: ignored. start and DONE in the same cycle: ignored; a new start is needed after busy drops.
- Minimum row time: SHIFTS_PER_ROW*(1+2*HALF_PER)+PUSH_CYC cycles.

Optional Feature:
- Macro PIXEL_CFG_READBACK_EN.
- Defined:
  - Adds input config_do and outputs rb_bit and rb_valid.
  - On the last clk_40MHz cycle of every CLK_LO (after the target has shifted), the driver samples config_do into rb_bit and pulses rb_valid for 1 cycle.
  - Reset/abort: rb_bit=0, rb_valid=0.
- Undefined: these ports and their logic are absent. No other behaviour changes.

Decomposition:
- Shared package pixel_cfg_pkg holds:
  - state enum
  - WORD_W, SHIFTS_PER_ROW, ROWS defaults
  - localparam ROW_BITS=WORD_W*SHIFTS_PER_ROW
- One sub-module, cfg_tick_cnt: a loadable down-counter with terminal flag, reused for HALF_PER and PUSH_CYC timing.
- Everything else stays in pixel_config_driver.

Test Plan:
- Reset mid-row: assert rst_n=0 during CLK_LO of shift 5 -> next cycle config_clk=1, config_en=0, push_en=0, busy=0, row_idx=0.
- SHIFTS_PER_ROW=4, ROWS=2, HALF_PER=2, din always valid with words 1..8:
  - exactly 8 falling config_clk edges, presenting 1,2,3,4 then 5,6,7,8
  - push_en high 4 cycles after edges 4 and 8
  - done pulses once
  - total 2*(4*5+4)+~2 cycles
- Backpressure: din_valid low for 10 cycles in FETCH -> config_clk stays 1, config_en stays 1, no edge; resume -> edge exactly 3 cycles after accept.
- abort asserted during PUSH of row 0 -> push_en low next cycle, busy=0, no done; a new start restarts at row_idx=0 with shift count 0.
- start held high while busy, and start simultaneous with abort -> no restart and no state change beyond the abort.
- With PIXEL_CFG_READBACK_EN, using a bench model of the 24-bit target chain: drive 4 words 0x3F,0,0,0 -> rb_bit sequence 0,0,0,1 at the four rb_valid pulses. Checks that sampling occurs after the target's shift.

Source files
------------

// File: rtl/pixel_cfg_pkg.sv
// Shared definitions for the pixel configuration driver.
// Holds the sequencer state encoding, default chain geometry and a width helper.
package pixel_cfg_pkg;

  localparam int unsigned DEF_WORD_W         = 6;
  localparam int unsigned DEF_SHIFTS_PER_ROW = 32;
  localparam int unsigned DEF_ROWS           = 128;
  localparam int unsigned ROW_BITS           = DEF_WORD_W * DEF_SHIFTS_PER_ROW;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_CLK_HI = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_PUSH   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_tick_cnt.sv
// Loadable down-counter with terminal flag, used to time clock half-periods
// and the push pulse.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : load load_val_i this cycle (overrides counting)
//   load_val_i    : value loaded; the flag rises load_val_i cycles later
//   tc_o          : counter is at zero
module cfg_tick_cnt
  import pixel_cfg_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pixel_config_driver.sv
// Transmit sequencer for the pixel configuration chain. Pulls config words
// over valid/ready, shifts SHIFTS_PER_ROW words per row with config_clk
// (target captures on the falling edge), pulses push_en per row, and flags
// done after ROWS rows.
//   clk_40MHz, rst_n        : clock, synchronous active-low reset
//   start, abort            : begin a configuration / cancel to idle
//   din, din_valid, din_ready : word input handshake (din_ready = FETCH decode)
//   busy, done, row_idx     : sequence status
//   config_clk, config_data, config_en, push_en : chain drive
// Optional macro PIXEL_CFG_READBACK_EN adds config_do/rb_bit/rb_valid: the
// chain output is sampled on the last cycle of every low clock phase.
module pixel_config_driver
  import pixel_cfg_pkg::*;
#(
  parameter int unsigned WORD_W         = DEF_WORD_W,
  parameter int unsigned SHIFTS_PER_ROW = DEF_SHIFTS_PER_ROW,
  parameter int unsigned ROWS           = DEF_ROWS,
  parameter int unsigned HALF_PER       = 2,
  parameter int unsigned PUSH_CYC       = 4
) (
  input  logic                          clk_40MHz,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [WORD_W-1:0]             din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          busy,
  output logic                          done,
  output logic [cnt_width(ROWS)-1:0]    row_idx,
  output logic                          config_clk,
  output logic [WORD_W-1:0]             config_data,
  output logic                          config_en,
  output logic                          push_en
`ifdef PIXEL_CFG_READBACK_EN
  ,
  input  logic                          config_do,
  output logic                          rb_bit,
  output logic                          rb_valid
`endif
);

  localparam int unsigned ROW_W    = cnt_width(ROWS);
  localparam int unsigned SC_W     = cnt_width(SHIFTS_PER_ROW);
  localparam int unsigned TICK_MAX = (HALF_PER > PUSH_CYC) ? HALF_PER : PUSH_CYC;
  localparam int unsigned TICK_W   = cnt_width(TICK_MAX);
  localparam logic [TICK_W-1:0] HALF_LOAD = TICK_W'(HALF_PER - 1);
  localparam logic [TICK_W-1:0] PUSH_LOAD = TICK_W'(PUSH_CYC - 1);

  state_e             state_q, state_d;
  logic               cfg_clk_q, cfg_clk_d;
  logic [WORD_W-1:0]  cfg_data_q, cfg_data_d;
  logic               cfg_en_q, cfg_en_d;
  logic               push_en_q, push_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ROW_W-1:0]   row_idx_q, row_idx_d;
  logic [SC_W-1:0]    shift_cnt_q, shift_cnt_d;
`ifdef PIXEL_CFG_READBACK_EN
  logic               rb_bit_q, rb_bit_d;
  logic               rb_valid_q, rb_valid_d;
`endif

  logic               tick_load;
  logic [TICK_W-1:0]  tick_val;
  logic               tick_tc;
  logic               last_shift;
  logic               last_row;

  // Phase timer: loaded on entry to CLK_HI, CLK_LO and PUSH.
  cfg_tick_cnt #(
    .W (TICK_W)
  ) u_tick (
    .clk_i      (clk_40MHz),
    .rst_ni     (rst_n),
    .load_i     (tick_load),
    .load_val_i (tick_val),
    .tc_o       (tick_tc)
  );

  assign last_shift = (shift_cnt_q == SC_W'(SHIFTS_PER_ROW - 1));
  assign last_row   = (row_idx_q == ROW_W'(ROWS - 1));

  // State and output registers.
  always_ff @(posedge clk_40MHz) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cfg_clk_q   <= 1'b1;
      cfg_data_q  <= '0;
      cfg_en_q    <= 1'b0;
      push_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_idx_q   <= '0;
      shift_cnt_q <= '0;
`ifdef PIXEL_CFG_READBACK_EN
      rb_bit_q    <= 1'b0;
      rb_valid_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cfg_clk_q   <= cfg_clk_d;
      cfg_data_q  <= cfg_data_d;
      cfg_en_q    <= cfg_en_d;
      push_en_q   <= push_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      row_idx_q   <= row_idx_d;
      shift_cnt_q <= shift_cnt_d;
`ifdef PIXEL_CFG_READBACK_EN
      rb_bit_q    <= rb_bit_d;
      rb_valid_q  <= rb_valid_d;
`endif
    end
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (start) state_d = ST_FETCH;
        ST_FETCH:  if (din_valid) state_d = ST_CLK_HI;
        ST_CLK_HI: if (tick_tc) state_d = ST_CLK_LO;
        ST_CLK_LO: if (tick_tc) state_d = last_shift ? ST_PUSH : ST_FETCH;
        ST_PUSH:   if (tick_tc) state_d = last_row ? ST_DONE : ST_FETCH;
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    cfg_clk_d   = cfg_clk_q;
    cfg_data_d  = cfg_data_q;
    cfg_en_d    = cfg_en_q;
    push_en_d   = push_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    row_idx_d   = row_idx_q;
    shift_cnt_d = shift_cnt_q;
    tick_load   = 1'b0;
    tick_val    = '0;
`ifdef PIXEL_CFG_READBACK_EN
    rb_bit_d    = rb_bit_q;
    rb_valid_d  = 1'b0;
`endif
    if (abort) begin
      // config_data keeps its last word; a falling edge already issued stays.
      cfg_clk_d   = 1'b1;
      cfg_en_d    = 1'b0;
      push_en_d   = 1'b0;
      busy_d      = 1'b0;
      row_idx_d   = '0;
      shift_cnt_d = '0;
      tick_load   = 1'b1;
`ifdef PIXEL_CFG_READBACK_EN
      rb_bit_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_d      = 1'b1;
            row_idx_d   = '0;
            shift_cnt_d = '0;
          end
        end
        ST_FETCH: begin
          if (din_valid) begin
            cfg_data_d = din;
            cfg_en_d   = 1'b1;
            tick_load  = 1'b1;
            tick_val   = HALF_LOAD;
          end
        end
        ST_CLK_HI: begin
          if (tick_tc) begin
            cfg_clk_d = 1'b0;
            tick_load = 1'b1;
            tick_val  = HALF_LOAD;
          end
        end
        ST_CLK_LO: begin
          if (tick_tc) begin
            cfg_clk_d = 1'b1;
`ifdef PIXEL_CFG_READBACK_EN
            // Target shifted at the falling edge, so its output is settled.
            rb_bit_d   = config_do;
            rb_valid_d = 1'b1;
`endif
            if (last_shift) begin
              shift_cnt_d = '0;
              cfg_en_d    = 1'b0;
              push_en_d   = 1'b1;
              tick_load   = 1'b1;
              tick_val    = PUSH_LOAD;
            end else begin
              shift_cnt_d = shift_cnt_q + SC_W'(1);
            end
          end
        end
        ST_PUSH: begin
          if (tick_tc) begin
            push_en_d = 1'b0;
            if (last_row) done_d = 1'b1;
            else          row_idx_d = row_idx_q + ROW_W'(1);
          end
        end
        ST_DONE: begin
          busy_d    = 1'b0;
          row_idx_d = '0;
        end
        default: ;
      endcase
    end
  end

  assign din_ready   = (state_q == ST_FETCH);
  assign busy        = busy_q;
  assign done        = done_q;
  assign row_idx     = row_idx_q;
  assign config_clk  = cfg_clk_q;
  assign config_data = cfg_data_q;
  assign config_en   = cfg_en_q;
  assign push_en     = push_en_q;
`ifdef PIXEL_CFG_READBACK_EN
  assign rb_bit      = rb_bit_q;
  assign rb_valid    = rb_valid_q;
`endif

endmodule

// File: tb/tb_pixel_config_driver.sv
// Directed bench for pixel_config_driver with a 4-word row, 2 rows,
// HALF_PER=2 and PUSH_CYC=4. With PIXEL_CFG_READBACK_EN a 24-bit target
// chain model feeds config_do.
module tb_pixel_config_driver;

  logic       clk_40MHz = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [5:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       busy;
  logic       done;
  logic [0:0] row_idx;
  logic       config_clk;
  logic [5:0] config_data;
  logic       config_en;
  logic       push_en;

  int n_cmp = 0;
  int n_bad = 0;

  int fall_cnt  = 0;
  int done_cnt  = 0;
  int push_cyc  = 0;
  int overlap   = 0;
  logic push_prev = 1'b0;
  logic [5:0] fall_data[$];
  int         push_starts[$];

  logic [5:0] feed [16];
  int         widx;

  always #5 clk_40MHz = ~clk_40MHz;

`ifdef PIXEL_CFG_READBACK_EN
  logic        config_do;
  logic        rb_bit;
  logic        rb_valid;
  logic [23:0] chain = '0;
  logic        rb_seq[$];

  // Target chain: shifts one word in on each falling config_clk.
  always @(negedge config_clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[17:0], config_data};
  end
  assign config_do = chain[23];

  always @(negedge clk_40MHz) begin
    if (rb_valid === 1'b1) rb_seq.push_back(rb_bit);
  end
`endif

  pixel_config_driver #(
    .WORD_W         (6),
    .SHIFTS_PER_ROW (4),
    .ROWS           (2),
    .HALF_PER       (2),
    .PUSH_CYC       (4)
  ) dut (
    .clk_40MHz   (clk_40MHz),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .busy        (busy),
    .done        (done),
    .row_idx     (row_idx),
    .config_clk  (config_clk),
    .config_data (config_data),
    .config_en   (config_en),
    .push_en     (push_en)
`ifdef PIXEL_CFG_READBACK_EN
    ,
    .config_do   (config_do),
    .rb_bit      (rb_bit),
    .rb_valid    (rb_valid)
`endif
  );

  always @(negedge config_clk) begin
    fall_cnt <= fall_cnt + 1;
    fall_data.push_back(config_data);
  end

  always @(negedge clk_40MHz) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (push_en === 1'b1) push_cyc <= push_cyc + 1;
    if (push_en === 1'b1 && config_en === 1'b1) overlap <= overlap + 1;
    if (push_en === 1'b1 && push_prev !== 1'b1) push_starts.push_back(fall_cnt);
    push_prev <= push_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; advances the feeder when the upcoming edge accepts a word.
  task automatic cyc();
    logic acc;
    acc = din_ready && din_valid && !abort && rst_n;
    @(negedge clk_40MHz);
    if (acc === 1'b1 && widx < 15) begin
      widx++;
      din = feed[widx];
    end
  endtask

  initial begin
    int base_fall;
    int base_done;
    int base_push;
    int base_ps;
    int busy_cycles;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; din_valid = 1'b0;
    for (int i = 0; i < 16; i++) feed[i] = 6'(i + 1);
    widx = 0; din = feed[0];
    repeat (3) cyc();

    // Reset values
    check("rst_config_clk",  32'(config_clk),  32'd1);
    check("rst_config_en",   32'(config_en),   32'd0);
    check("rst_push_en",     32'(push_en),     32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_done",        32'(done),        32'd0);
    check("rst_din_ready",   32'(din_ready),   32'd0);
    check("rst_row_idx",     32'(row_idx),     32'd0);
    check("rst_config_data", 32'(config_data), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Full configuration with din always valid, words 1..8
    base_fall = fall_cnt; base_done = done_cnt; base_push = push_cyc;
    base_ps = push_starts.size();
    widx = 0; din = feed[0]; din_valid = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 70; i++) begin
      cyc();
      if (busy === 1'b1) busy_cycles++;
    end
    check("full_busy_cycles", 32'(busy_cycles), 32'd49);
    check("full_fall_edges",  32'(fall_cnt - base_fall), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("full_word%0d", i), 32'(fall_data[base_fall + i]), 32'(i + 1));
    check("full_push_cycles", 32'(push_cyc - base_push), 32'd8);
    check("full_push_count",  32'(push_starts.size() - base_ps), 32'd2);
    check("full_push0_after", 32'(push_starts[base_ps] - base_fall), 32'd4);
    check("full_push1_after", 32'(push_starts[base_ps + 1] - base_fall), 32'd8);
    check("full_done_pulses", 32'(done_cnt - base_done), 32'd1);
    check("full_en_push_overlap", 32'(overlap), 32'd0);
    check("full_idle_busy",   32'(busy), 32'd0);

    // Backpressure between words
    din_valid = 1'b0;
    base_fall = fall_cnt; base_done = done_cnt;
    widx = 0; din = feed[0]; din_valid = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    din_valid = 1'b0;
    for (int i = 0; i < 20 && din_ready !== 1'b1; i++) cyc();
    check("bp_reach_fetch", 32'(din_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("bp_stall_clk", 32'(config_clk), 32'd1);
      check("bp_stall_en",  32'(config_en),  32'd1);
    end
    check("bp_stall_edges", 32'(fall_cnt - base_fall), 32'd1);
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    cyc();
    check("bp_edge_not_yet", 32'(config_clk), 32'd1);
    cyc();
    check("bp_edge_at_3", 32'(config_clk), 32'd0);
    check("bp_edges_after", 32'(fall_cnt - base_fall), 32'd2);
    check("bp_word2", 32'(config_data), 32'd2);

    // Abort during PUSH of row 0, with start asserted in the same cycle
    din_valid = 1'b1;
    for (int i = 0; i < 60 && push_en !== 1'b1; i++) cyc();
    check("ab_in_push", 32'(push_en), 32'd1);
    check("ab_push_row", 32'(row_idx), 32'd0);
    abort = 1'b1; start = 1'b1;
    cyc();
    abort = 1'b0; start = 1'b0;
    check("ab_push_en",   32'(push_en),    32'd0);
    check("ab_busy",      32'(busy),       32'd0);
    check("ab_config_en", 32'(config_en),  32'd0);
    check("ab_config_clk",32'(config_clk), 32'd1);
    check("ab_din_ready", 32'(din_ready),  32'd0);
    cyc();
    check("ab_no_restart", 32'(busy), 32'd0);
    check("ab_no_done", 32'(done_cnt - base_done), 32'd0);

    // Restart with start held high while busy
    base_fall = fall_cnt; base_done = done_cnt;
    widx = 0; din = feed[0]; din_valid = 1'b1;
    start = 1'b1;
    cyc();
    check("rs_busy", 32'(busy), 32'd1);
    check("rs_row0", 32'(row_idx), 32'd0);
    for (int i = 0; i < 60 && push_en !== 1'b1; i++) cyc();
    check("rs_push_after4", 32'(fall_cnt - base_fall), 32'd4);
    for (int i = 0; i < 20 && din_ready !== 1'b1; i++) cyc();
    check("rs_row1_kept", 32'(row_idx), 32'd1);
    start = 1'b0;
    for (int i = 0; i < 80 && busy !== 1'b0; i++) cyc();
    cyc();
    check("rs_done_once", 32'(done_cnt - base_done), 32'd1);
    check("rs_edges", 32'(fall_cnt - base_fall), 32'd8);
    check("rs_idle", 32'(busy), 32'd0);

    // Reset during CLK_LO of shift 5
    base_fall = fall_cnt;
    widx = 0; din = feed[0]; din_valid = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 100 && !((fall_cnt - base_fall) == 5 && config_clk === 1'b0); i++) cyc();
    check("mr_in_clk_lo", 32'(config_clk), 32'd0);
    check("mr_row1", 32'(row_idx), 32'd1);
    rst_n = 1'b0;
    cyc();
    check("mr_config_clk", 32'(config_clk), 32'd1);
    check("mr_config_en",  32'(config_en),  32'd0);
    check("mr_push_en",    32'(push_en),    32'd0);
    check("mr_busy",       32'(busy),       32'd0);
    check("mr_row_idx",    32'(row_idx),    32'd0);
    check("mr_din_ready",  32'(din_ready),  32'd0);
    rst_n = 1'b1;
    din_valid = 1'b0;
    cyc();

`ifdef PIXEL_CFG_READBACK_EN
    // Readback: 0x3F,0,0,0 through the 24-bit chain
    begin
      int base_rb;
      feed[0] = 6'h3F;
      for (int i = 1; i < 16; i++) feed[i] = 6'h00;
      base_rb = rb_seq.size();
      widx = 0; din = feed[0]; din_valid = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 60 && push_en !== 1'b1; i++) cyc();
      cyc(); cyc();
      check("rb_count", 32'(rb_seq.size() - base_rb), 32'd4);
      if (rb_seq.size() - base_rb >= 4) begin
        check("rb_bit0", 32'(rb_seq[base_rb]),     32'd0);
        check("rb_bit1", 32'(rb_seq[base_rb + 1]), 32'd0);
        check("rb_bit2", 32'(rb_seq[base_rb + 2]), 32'd0);
        check("rb_bit3", 32'(rb_seq[base_rb + 3]), 32'd1);
      end
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check("rb_abort_clear", 32'(rb_bit), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
